reg_cmd_bridge: RTL and testbench
=================================

REG_CMD_BRIDGE -- requirements
Module: reg_cmd_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the maximum idle gap in cycles between frame bytes before the frame is aborted.
REQ-002 The block SHALL have parameter NUM_REGS, default 16, giving the number of valid register addresses (0..NUM_REGS-1).
REQ-003 clk_in  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rx_data_i  in  8  received byte from the serial receiver.
REQ-006 rx_valid_i  in  1  rx_data_i valid; a byte transfers when rx_valid_i and rx_ready_o are both 1.
REQ-007 rx_ready_o  out  1  bridge can accept a byte.
REQ-008 tx_data_o  out  8  byte to the serial transmitter.
REQ-009 tx_valid_o  out  1  tx_data_o valid; a byte transfers when tx_valid_o and tx_ready_i are both 1.
REQ-010 tx_ready_i  in  1  transmitter can accept a byte.
REQ-011 write_enable_o  out  1  one-cycle register write strobe to the register file.
REQ-012 w_addr_o  out  8  register write address.
REQ-013 w_data_o  out  16  register write data.
REQ-014 r_addr_o  out  8  register read address.
REQ-015 r_data_i  in  16  register read data, registered by the register file (1-cycle read latency).
REQ-016 err_o  out  1  one-cycle pulse on a protocol error (bad command, timeout).

Function
REQ-017 Frames SHALL be: write = 0x57, addr, data[15:8], data[7:0]; read = 0x52, addr.
REQ-018 The FSM SHALL have states IDLE, ADDR, DHI, DLO, WR, RD0, RD1, TX_HI, TX_LO, TX_RSP.
REQ-019 rx_ready_o SHALL be 1 only in IDLE, ADDR, DHI and DLO, and 0 in all other states.
REQ-020 In IDLE, a 0x57 byte SHALL go to ADDR with the frame marked write, and a 0x52 byte SHALL go to ADDR with the frame marked read.
REQ-021 In IDLE, any other byte SHALL be dropped, pulse err_o, and stay in IDLE.
REQ-022 ADDR SHALL latch the address byte.
REQ-023 If the latched address is >= NUM_REGS, the block SHALL go to TX_RSP with response 0x15 (NAK), perform no write and no read, and still consume DHI/DLO bytes first for write frames.
REQ-024 If the address is valid, a write frame SHALL go ADDR -> DHI -> DLO -> WR, and a read frame SHALL go ADDR -> RD0.
REQ-025 WR SHALL assert write_enable_o for exactly one cycle with w_addr_o and w_data_o stable in that cycle, then go to TX_RSP with response 0x06 (ACK).
REQ-026 RD0 SHALL drive r_addr_o with the address; RD1 follows RD0; r_data_i SHALL be sampled into a 16-bit holding register at the end of RD1 (two edges after r_addr_o is driven).
REQ-027 From RD1 the FSM SHALL go to TX_HI.
REQ-028 TX_HI SHALL present data[15:8], TX_LO SHALL present data[7:0], and TX_RSP SHALL present the response byte, each with tx_valid_o=1.
REQ-029 Each TX state SHALL advance only on the cycle tx_valid_o and tx_ready_i are both 1; tx_data_o SHALL be held stable while tx_ready_i=0.
REQ-030 TX_HI SHALL go to TX_LO, TX_LO SHALL go to IDLE (a read returns no ACK), and TX_RSP SHALL go to IDLE.
REQ-031 A gap counter SHALL clear on every accepted byte and increment each cycle in ADDR, DHI and DLO.
REQ-032 When the gap counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, pulse err_o, and perform no write.
REQ-033 If a byte is accepted in the same cycle the timeout is reached, the byte SHALL win.
REQ-034 w_addr_o, w_data_o and r_addr_o SHALL hold their last values outside WR/RD0/RD1.
REQ-035 Only one frame SHALL be in flight at a time; there is no queuing.

Reset
REQ-036 Asserting reset (0) SHALL immediately force IDLE, with rx_ready_o=1 after the reset clock edge; tx_valid_o=0, tx_data_o=0x00, write_enable_o=0, err_o=0, w_addr_o=0, w_data_o=0x0000, r_addr_o=0, gap counter=0, and holding register=0.
REQ-037 A reset asserted mid-frame or mid-transmit SHALL abort the frame with no write strobe and no further tx_valid_o.

Verification
REQ-038 Bytes 57 03 12 34 with tx_ready_i=1 -> exactly one write_enable_o pulse with w_addr_o=0x03 and w_data_o=0x1234, then tx byte 0x06.
REQ-039 Bytes 52 0E with r_data_i=0xBEEF -> r_addr_o=0x0E, then tx bytes 0xBE then 0xEF, no ACK byte.
REQ-040 Bytes 57 10 AA BB -> no write_enable_o, tx byte 0x15; also bytes 52 20 -> tx byte 0x15 with no data bytes.
REQ-041 Byte 0x41 in IDLE -> one err_o pulse, state stays IDLE; bytes 57 02 then a silence of TIMEOUT_CYCLES (set to 8) -> err_o pulse, no write, next frame 57 02 00 05 -> normal write.
REQ-042 During a read response, hold tx_ready_i=0 for 5 cycles -> tx_data_o stays 0xBE, rx_ready_o=0, and both bytes are delivered once tx_ready_i=1.
REQ-043 Assert reset after byte DHI of a write frame -> no write_enable_o ever, all outputs at reset values, and a fresh frame after release works.

Source files
------------

// File: rtl/reg_cmd_bridge.sv
// reg_cmd_bridge
//   Byte-stream command bridge between a serial receiver/transmitter pair and
//   a simple register file.
//
//   Frames received on the rx byte stream:
//     write : 0x57, addr, data[15:8], data[7:0]  -> register write, reply 0x06
//     read  : 0x52, addr                         -> reply data[15:8], data[7:0]
//   An out-of-range address is answered with 0x15 and touches no register.
//   An unknown command byte, or an idle gap of TIMEOUT_CYCLES inside a frame,
//   produces a one-cycle err_o pulse and the frame is dropped.
//
// Ports
//   clk_in          single clock, rising-edge
//   reset           asynchronous reset, active low
//   rx_data_i       received byte
//   rx_valid_i      rx byte valid
//   rx_ready_o      bridge can accept a byte (only while collecting a frame)
//   tx_data_o       byte to transmitter
//   tx_valid_o      tx byte valid
//   tx_ready_i      transmitter can accept a byte
//   write_enable_o  one-cycle register write strobe
//   w_addr_o        register write address
//   w_data_o        register write data
//   r_addr_o        register read address
//   r_data_i        register read data (registered, 1-cycle latency)
//   err_o           one-cycle protocol error pulse
module reg_cmd_bridge #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NUM_REGS       = 16
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        write_enable_o,
  output logic [7:0]  w_addr_o,
  output logic [15:0] w_data_o,
  output logic [7:0]  r_addr_o,
  input  logic [15:0] r_data_i,
  output logic        err_o
);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  localparam int GAP_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] TIMEOUT_VAL = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [8:0] NUM_REGS_V = 9'(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ADDR   = 4'd1,
    DHI    = 4'd2,
    DLO    = 4'd3,
    WR     = 4'd4,
    RD0    = 4'd5,
    RD1    = 4'd6,
    TX_HI  = 4'd7,
    TX_LO  = 4'd8,
    TX_RSP = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              is_wr_q, is_wr_d;
  logic              addr_ok_q, addr_ok_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        dhi_q, dhi_d;
  logic [7:0]        w_addr_q, w_addr_d;
  logic [15:0]       w_data_q, w_data_d;
  logic [7:0]        r_addr_q, r_addr_d;
  logic [15:0]       hold_q, hold_d;
  logic [7:0]        rsp_q, rsp_d;
  logic              err_q, err_d;

  logic rx_fire;
  logic in_frame;
  logic rx_addr_ok;

  always_comb begin
    rx_ready_o = (state_q == IDLE) || (state_q == ADDR) ||
                 (state_q == DHI)  || (state_q == DLO);
    in_frame   = (state_q == ADDR) || (state_q == DHI) || (state_q == DLO);
    rx_fire    = rx_valid_i && rx_ready_o;
    rx_addr_ok = ({1'b0, rx_data_i} < NUM_REGS_V);
  end

  // Next-state logic. The gap counter is handled first so that an accepted
  // byte in the state case below overrides a timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    is_wr_d   = is_wr_q;
    addr_ok_d = addr_ok_q;
    addr_d    = addr_q;
    dhi_d     = dhi_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    r_addr_d  = r_addr_q;
    hold_d    = hold_q;
    rsp_d     = rsp_q;
    err_d     = 1'b0;

    if (rx_fire) begin
      gap_d = '0;
    end else if (in_frame) begin
      if (gap_q == TIMEOUT_VAL) begin
        gap_d   = '0;
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if (rx_data_i == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = ADDR;
          end else if (rx_data_i == CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_fire) begin
          addr_d    = rx_data_i;
          addr_ok_d = rx_addr_ok;
          if (is_wr_q) begin
            // Bad-address writes still consume their data bytes.
            state_d = DHI;
          end else if (rx_addr_ok) begin
            r_addr_d = rx_data_i;
            state_d  = RD0;
          end else begin
            rsp_d   = RSP_NAK;
            state_d = TX_RSP;
          end
        end
      end
      DHI: begin
        if (rx_fire) begin
          dhi_d   = rx_data_i;
          state_d = DLO;
        end
      end
      DLO: begin
        if (rx_fire) begin
          if (addr_ok_q) begin
            w_addr_d = addr_q;
            w_data_d = {dhi_q, rx_data_i};
            state_d  = WR;
          end else begin
            rsp_d   = RSP_NAK;
            state_d = TX_RSP;
          end
        end
      end
      WR: begin
        rsp_d   = RSP_ACK;
        state_d = TX_RSP;
      end
      RD0: begin
        state_d = RD1;
      end
      RD1: begin
        // r_addr_o was driven from the start of RD0; the register file's
        // output is valid here, two edges later.
        hold_d  = r_data_i;
        state_d = TX_HI;
      end
      TX_HI: begin
        if (tx_ready_i) state_d = TX_LO;
      end
      TX_LO: begin
        if (tx_ready_i) state_d = IDLE;
      end
      TX_RSP: begin
        if (tx_ready_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      is_wr_q   <= 1'b0;
      addr_ok_q <= 1'b0;
      addr_q    <= 8'h00;
      dhi_q     <= 8'h00;
      w_addr_q  <= 8'h00;
      w_data_q  <= 16'h0000;
      r_addr_q  <= 8'h00;
      hold_q    <= 16'h0000;
      rsp_q     <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      is_wr_q   <= is_wr_d;
      addr_ok_q <= addr_ok_d;
      addr_q    <= addr_d;
      dhi_q     <= dhi_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      r_addr_q  <= r_addr_d;
      hold_q    <= hold_d;
      rsp_q     <= rsp_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    tx_valid_o     = 1'b0;
    tx_data_o      = 8'h00;
    unique case (state_q)
      TX_HI: begin
        tx_valid_o = 1'b1;
        tx_data_o  = hold_q[15:8];
      end
      TX_LO: begin
        tx_valid_o = 1'b1;
        tx_data_o  = hold_q[7:0];
      end
      TX_RSP: begin
        tx_valid_o = 1'b1;
        tx_data_o  = rsp_q;
      end
      default: begin
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
      end
    endcase
    write_enable_o = (state_q == WR);
    w_addr_o       = w_addr_q;
    w_data_o       = w_data_q;
    r_addr_o       = r_addr_q;
    err_o          = err_q;
  end

endmodule

// File: tb/tb_reg_cmd_bridge.sv
module tb_reg_cmd_bridge;

  logic        clk_in;
  logic        reset;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        write_enable_o;
  logic [7:0]  w_addr_o;
  logic [15:0] w_data_o;
  logic [7:0]  r_addr_o;
  logic [15:0] r_data_i;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  int          we_cnt = 0;
  logic [7:0]  we_addr = 8'h00;
  logic [15:0] we_data = 16'h0000;
  int          err_cnt = 0;
  logic [7:0]  txq[$];

  reg_cmd_bridge #(
    .TIMEOUT_CYCLES(8),
    .NUM_REGS(16)
  ) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .rx_data_i      (rx_data_i),
    .rx_valid_i     (rx_valid_i),
    .rx_ready_o     (rx_ready_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .write_enable_o (write_enable_o),
    .w_addr_o       (w_addr_o),
    .w_data_o       (w_data_o),
    .r_addr_o       (r_addr_o),
    .r_data_i       (r_data_i),
    .err_o          (err_o)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Register file stand-in: registered read, one known location.
  always @(posedge clk_in) begin
    r_data_i <= (r_addr_o == 8'h0E) ? 16'hBEEF : 16'h0000;
  end

  // Observe handshakes between edges.
  always @(negedge clk_in) begin
    if (write_enable_o) begin
      we_cnt  = we_cnt + 1;
      we_addr = w_addr_o;
      we_data = w_data_o;
    end
    if (err_o) err_cnt = err_cnt + 1;
    if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    we_cnt  = 0;
    err_cnt = 0;
    txq.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (rx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rx_ready_wait", {31'd0, rx_ready_o}, 32'd1);
    @(posedge clk_in);
    #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready_o}, 32'd1);
    check({tag, "_tx_valid"}, {31'd0, tx_valid_o}, 32'd0);
    check({tag, "_tx_data"},  {24'd0, tx_data_o},  32'h00);
    check({tag, "_we"},       {31'd0, write_enable_o}, 32'd0);
    check({tag, "_err"},      {31'd0, err_o},      32'd0);
    check({tag, "_w_addr"},   {24'd0, w_addr_o},   32'h00);
    check({tag, "_w_data"},   {16'd0, w_data_o},   32'h0000);
    check({tag, "_r_addr"},   {24'd0, r_addr_o},   32'h00);
  endtask

  initial begin
    reset      = 1'b0;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("rst");
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    idle_cycles(2);

    // Write 0x1234 to register 3, expect a single strobe and ACK.
    clear_obs();
    send_byte(8'h57); send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
    idle_cycles(6);
    check("wr_pulses", we_cnt, 1);
    check("wr_addr", {24'd0, we_addr}, 32'h03);
    check("wr_data", {16'd0, we_data}, 32'h1234);
    check("wr_tx_n", txq.size(), 1);
    check("wr_ack", {24'd0, txq[0]}, 32'h06);
    check("wr_addr_hold", {24'd0, w_addr_o}, 32'h03);
    check("wr_data_hold", {16'd0, w_data_o}, 32'h1234);

    // Read register 0x0E, expect BE EF and no ACK.
    clear_obs();
    send_byte(8'h52); send_byte(8'h0E);
    idle_cycles(8);
    check("rd_r_addr", {24'd0, r_addr_o}, 32'h0E);
    check("rd_tx_n", txq.size(), 2);
    check("rd_hi", {24'd0, txq[0]}, 32'hBE);
    check("rd_lo", {24'd0, txq[1]}, 32'hEF);
    check("rd_no_we", we_cnt, 0);

    // Out-of-range write and read: NAK only.
    clear_obs();
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hAA); send_byte(8'hBB);
    idle_cycles(6);
    check("nakw_no_we", we_cnt, 0);
    check("nakw_tx_n", txq.size(), 1);
    check("nakw_rsp", {24'd0, txq[0]}, 32'h15);
    clear_obs();
    send_byte(8'h52); send_byte(8'h20);
    idle_cycles(6);
    check("nakr_tx_n", txq.size(), 1);
    check("nakr_rsp", {24'd0, txq[0]}, 32'h15);
    check("nakr_r_addr", {24'd0, r_addr_o}, 32'h0E);

    // Unknown command byte.
    clear_obs();
    send_byte(8'h41);
    idle_cycles(3);
    check("badcmd_err", err_cnt, 1);
    check("badcmd_idle", {31'd0, rx_ready_o}, 32'd1);
    check("badcmd_tx_n", txq.size(), 0);

    // Timeout after address byte, then a normal write.
    clear_obs();
    send_byte(8'h57); send_byte(8'h02);
    idle_cycles(20);
    check("tmo_err", err_cnt, 1);
    check("tmo_no_we", we_cnt, 0);
    check("tmo_tx_n", txq.size(), 0);
    clear_obs();
    send_byte(8'h57); send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    idle_cycles(6);
    check("post_tmo_we", we_cnt, 1);
    check("post_tmo_addr", {24'd0, we_addr}, 32'h02);
    check("post_tmo_data", {16'd0, we_data}, 32'h0005);
    check("post_tmo_ack", {24'd0, txq[0]}, 32'h06);

    // Gaps just under the timeout do not abort the frame.
    clear_obs();
    send_byte(8'h57); idle_cycles(6);
    send_byte(8'h04); idle_cycles(6);
    send_byte(8'hA5); idle_cycles(6);
    send_byte(8'h5A);
    idle_cycles(6);
    check("slow_err", err_cnt, 0);
    check("slow_we", we_cnt, 1);
    check("slow_data", {16'd0, we_data}, 32'hA55A);

    // Back-pressure during a read response.
    clear_obs();
    tx_ready_i = 1'b0;
    send_byte(8'h52); send_byte(8'h0E);
    idle_cycles(5);
    @(negedge clk_in);
    check("bp_valid", {31'd0, tx_valid_o}, 32'd1);
    check("bp_data_a", {24'd0, tx_data_o}, 32'hBE);
    check("bp_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    idle_cycles(5);
    @(negedge clk_in);
    check("bp_data_b", {24'd0, tx_data_o}, 32'hBE);
    check("bp_tx_n", txq.size(), 0);
    @(posedge clk_in);
    #1;
    tx_ready_i = 1'b1;
    idle_cycles(5);
    check("bp_tx_n2", txq.size(), 2);
    check("bp_hi", {24'd0, txq[0]}, 32'hBE);
    check("bp_lo", {24'd0, txq[1]}, 32'hEF);

    // Reset in the middle of a write frame.
    clear_obs();
    send_byte(8'h57); send_byte(8'h05); send_byte(8'h77);
    reset = 1'b0;
    @(negedge clk_in);
    check_reset_outputs("midrst");
    idle_cycles(2);
    reset = 1'b1;
    idle_cycles(10);
    check("midrst_no_we", we_cnt, 0);
    check("midrst_tx_n", txq.size(), 0);
    clear_obs();
    send_byte(8'h57); send_byte(8'h07); send_byte(8'hCA); send_byte(8'hFE);
    idle_cycles(6);
    check("fresh_we", we_cnt, 1);
    check("fresh_addr", {24'd0, we_addr}, 32'h07);
    check("fresh_data", {16'd0, we_data}, 32'hCAFE);
    check("fresh_ack", {24'd0, txq[0]}, 32'h06);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
